// File: rtl/mccpu_mem.sv
// mccpu_mem: unified instruction/data memory responder for the multicycle CPU.
// One word access at a time via req/ready, with WAIT_CYCLES wait states.
// Optional debug MMIO window (LED register, cycle counter) when
// MCCPU_MEM_MMIO_EN is defined; otherwise every address maps to the RAM.
module mccpu_mem #(
    parameter int unsigned AW          = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic [15:0] led
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = 4;
    localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   adr_q, adr_n;
    logic [31:0]   wdata_q, wdata_n;
    logic          we_q, we_n;
    logic [31:0]   rdata_n;
    logic          ready_n, err_n, busy_n;

    logic [31:0]   mem [DEPTH];

    logic          acc;
    logic [31:0]   adr_sel;
    logic          mis_sel;
    logic [31:0]   ram_word;
    logic [31:0]   rd_word;
    logic          mmio_q;
    logic          commit;
    logic          ram_we;

    // The address that the response will use: live inputs on accept, latched copy otherwise.
    assign acc      = (state == S_IDLE) && req;
    assign adr_sel  = acc ? adr : adr_q;
    assign mis_sel  = (adr_sel[1:0] != 2'b00);
    assign ram_word = mem[adr_sel[AW+1:2]];

    // An aligned write retires at the edge that ends RESP.
    assign commit = (state == S_RESP) && we_q && (adr_q[1:0] == 2'b00);
    assign ram_we = commit && !mmio_q;

`ifdef MCCPU_MEM_MMIO_EN
    logic [31:0] cyc_cnt;

    assign mmio_q = (adr_q[31:16] == 16'hFFFF);

    // Read mux: MMIO window at 0xFFFF_xxxx, RAM elsewhere.
    always_comb begin
        rd_word = ram_word;
        if (adr_sel[31:16] == 16'hFFFF) begin
            case (adr_sel[15:0])
                16'h0000: rd_word = {16'h0000, led};
                16'h0004: rd_word = cyc_cnt;
                default:  rd_word = '0;
            endcase
        end
    end

    // LED register write and free-running cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led     <= '0;
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (commit && mmio_q && (adr_q[15:0] == 16'h0000)) begin
                led <= wdata_q[15:0];
            end
        end
    end
`else
    logic unused_adr;

    assign mmio_q     = 1'b0;
    assign led        = '0;
    assign rd_word    = ram_word;
    assign unused_adr = ^adr_q[31:AW+2];
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        adr_n   = adr_q;
        we_n    = we_q;
        wdata_n = wdata_q;
        rdata_n = rdata;
        err_n   = err;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    adr_n   = adr;
                    we_n    = we;
                    wdata_n = wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_n = S_RESP;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_RESP;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (state_n == S_RESP) begin
            err_n   = mis_sel;
            rdata_n = mis_sel ? '0 : rd_word;
        end
        ready_n = (state_n == S_RESP);
        busy_n  = (state_n != S_IDLE);
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            adr_q   <= adr_n;
            we_q    <= we_n;
            wdata_q <= wdata_n;
            rdata   <= rdata_n;
            ready   <= ready_n;
            err     <= err_n;
            busy    <= busy_n;
        end
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[adr_q[AW+1:2]] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mccpu_mem.sv
// tb_mccpu_mem: randomized scoreboard bench for mccpu_mem (AW=10, WAIT_CYCLES=2).
// Honours MCCPU_MEM_MMIO_EN in its reference model the same way the design does.
module tb_mccpu_mem;
    localparam int W = 2;

`ifdef MCCPU_MEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;
    logic [15:0] led;

    mccpu_mem #(.AW(10), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .adr(adr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .busy(busy), .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          acc;
        int          due;
        logic [31:0] rd;
        bit          chk_rd;
        bit          er;
        bit          ctr;
        bit          ledw;
        logic [15:0] ledv;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] mdl [1024];
    bit          known [1024];
    logic [15:0] mdl_led = '0;
    logic [15:0] exp_led = '0;
    bit          have_prev = 1'b0;
    logic [31:0] prev_rd = '0;
    int          prev_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour of one accepted access, applied to the bench's memory image.
    function automatic exp_t predict(input bit w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        e = '{acc: 0, due: 0, rd: 32'h0, chk_rd: 1'b1, er: 1'b0, ctr: 1'b0, ledw: 1'b0, ledv: 16'h0};
        idx = int'(a[11:2]);
        if (a[1:0] != 2'b00) begin
            e.er = 1'b1;
        end else if (MMIO && a[31:16] == 16'hFFFF) begin
            if (a[15:0] == 16'h0000) begin
                e.rd = {16'h0000, mdl_led};
                if (w) begin
                    e.ledw  = 1'b1;
                    e.ledv  = d[15:0];
                    mdl_led = d[15:0];
                end
            end else if (a[15:0] == 16'h0004) begin
                e.ctr    = 1'b1;
                e.chk_rd = 1'b0;
            end
        end else begin
            e.rd     = mdl[idx];
            e.chk_rd = known[idx];
            if (w) begin
                mdl[idx]   = d;
                known[idx] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic idle(input int n);
        req   = 1'b0;
        we    = 1'($urandom);
        adr   = $urandom;
        wdata = $urandom;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one request in the current IDLE cycle; abort>=0 asserts reset that many edges after accept.
    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, input int abort);
        exp_t        e;
        int          idx;
        logic [31:0] old_m;
        bit          old_k;
        logic [15:0] old_l;
        req   = 1'b1;
        we    = w;
        adr   = a;
        wdata = d;
        @(posedge clk);
        #1;
        idx   = int'(a[11:2]);
        old_m = mdl[idx];
        old_k = known[idx];
        old_l = mdl_led;
        e     = predict(w, a, d);
        e.acc = cyc;
        e.due = cyc + W;
        q.push_back(e);
        if (!hold) begin
            req   = 1'b0;
            we    = 1'($urandom);
            adr   = $urandom;
            wdata = $urandom;
        end
        if (abort >= 0) begin
            repeat (abort) @(posedge clk);
            #1;
            rst = 1'b0;
            q.delete();
            mdl[idx]   = old_m;
            known[idx] = old_k;
            mdl_led    = 16'h0;
            exp_led    = 16'h0;
            have_prev  = 1'b0;
            req        = 1'b0;
            #1;
            chk("abort_ready", 32'(ready), 32'h0);
            chk("abort_busy", 32'(busy), 32'h0);
            chk("abort_led", 32'(led), 32'h0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
        end else begin
            repeat (W + 1) @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares registered outputs against the scoreboard at every falling edge.
    initial begin
        exp_t e;
        bit   exp_busy;
        forever begin
            @(negedge clk);
            chk("led", 32'(led), 32'(exp_led));
            exp_busy = (q.size() > 0) && (cyc >= q[0].acc) && (cyc <= q[0].due);
            chk("busy", 32'(busy), 32'(exp_busy));
            if (ready) begin
                if (q.size() == 0) begin
                    chk("ready_unexpected", 32'(ready), 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("ready_cycle", 32'(cyc), 32'(e.due));
                    chk("err", 32'(err), 32'(e.er));
                    if (e.chk_rd) chk("rdata", rdata, e.rd);
                    if (e.ctr) begin
                        if (have_prev) chk("ctr_delta", rdata - prev_rd, 32'(e.acc - prev_acc));
                        have_prev = 1'b1;
                        prev_rd   = rdata;
                        prev_acc  = e.acc;
                    end
                    if (e.ledw) exp_led = e.ledv;
                end
            end else if (q.size() > 0 && cyc >= q[0].due) begin
                chk("ready_missing", 32'(ready), 32'h1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          sel;
        int          wait_n;
        for (int i = 0; i < 1024; i++) begin
            known[i] = 1'b0;
            mdl[i]   = '0;
        end
        #1 rst = 1'b0;
        #2;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_led", 32'(led), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Read timing against a known word.
        access(1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 1'b0, -1);
        idle(2);
        access(1'b0, 32'h0000_000C, 32'h0, 1'b0, -1);
        // Write-then-read; the second write's RESP shows the old value.
        access(1'b1, 32'h0000_0040, 32'h1111_1111, 1'b0, -1);
        access(1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0, -1);
        access(1'b0, 32'h0000_0040, 32'h0, 1'b0, -1);
        // Misaligned write is flagged and suppressed.
        access(1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 1'b0, -1);
        access(1'b0, 32'h0000_0040, 32'h0, 1'b0, -1);
        access(1'b0, 32'h0000_0043, 32'h0, 1'b0, -1);
        // Aliasing every 4 KiB.
        access(1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 1'b0, -1);
        access(1'b0, 32'h0000_0000, 32'h0, 1'b0, -1);
        // Reset one cycle after accept drops the write.
        access(1'b1, 32'h0000_0008, 32'h0BAD_F00D, 1'b0, -1);
        access(1'b1, 32'h0000_0008, 32'h5555_5555, 1'b0, 1);
        access(1'b0, 32'h0000_0008, 32'h0, 1'b0, -1);
        // Continuous req: back-to-back accepts every W+2 cycles.
        for (int i = 0; i < 5; i++) access(1'b0, 32'h0000_0040, 32'h0, 1'b1, -1);
        idle(1);
        // MMIO window (or RAM word 0/1 aliases when not compiled in).
        access(1'b1, 32'hFFFF_0000, 32'h0000_BEEF, 1'b0, -1);
        access(1'b0, 32'hFFFF_0000, 32'h0, 1'b0, -1);
        access(1'b0, 32'h0000_0000, 32'h0, 1'b0, -1);
        access(1'b0, 32'hFFFF_0004, 32'h0, 1'b0, -1);
        idle(7);
        access(1'b0, 32'hFFFF_0004, 32'h0, 1'b0, -1);
        access(1'b1, 32'hFFFF_0004, 32'h1234_0000, 1'b0, -1);
        access(1'b0, 32'hFFFF_0008, 32'h0, 1'b0, -1);
        idle(2);

        // Randomized traffic, with occasional reset in WAIT or RESP.
        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                a = 32'hFFFF_0000 | (32'($urandom_range(0, 2)) << 2) | 32'($urandom_range(0, 1));
            end else begin
                a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2);
                if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            end
            access(1'($urandom), a, $urandom, 1'($urandom),
                   ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, W)) : -1);
            if ($urandom_range(0, 2) == 0) begin
                wait_n = int'($urandom_range(1, 3));
                idle(wait_n);
            end
        end

        idle(1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #1;
        if (q.size() > 0) chk("drain", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mccpu_mem.md
# mccpu_mem

Unified instruction/data memory responder for the multicycle CPU. It sits on the memory side of the CPU's `adr`/`MemWrite`/`writedata`/`readdata` bus and services one word access at a time through a request/ready handshake with configurable wait states. It holds a word-addressed RAM and an optional memory-mapped I/O window for board debug.

## Interface
Parameters:
- `AW`, default 10: word-address width; RAM holds 2^AW 32-bit words.
- `WAIT_CYCLES`, default 1: wait states inserted between request accept and response, legal range 0..15.

Ports:
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `req`, input, 1: access request, sampled only in IDLE.
- `we`, input, 1: write when 1 and read when 0; connected to the CPU `MemWrite`.
- `adr`, input, 32: byte address.
- `wdata`, input, 32: write data.
- `rdata`, output, 32: read data; valid only while `ready` is 1.
- `ready`, output, 1: one-cycle response pulse.
- `err`, output, 1: misaligned-access flag; pulses together with `ready`.
- `busy`, output, 1: high from the cycle after accept through the RESP cycle.
- `led`, output, 16: MMIO LED register; tied to 0 when MMIO is not compiled in.

## Operation
- The FSM has three states: IDLE, WAIT, RESP. All outputs are registered.
- IDLE with `req`=1 accepts the request. `adr`, `we` and `wdata` are latched into internal registers.
  - If `WAIT_CYCLES`>0, the next state is WAIT and the wait counter loads `WAIT_CYCLES`-1.
  - If `WAIT_CYCLES`=0, the next state is RESP.
- WAIT decrements the counter and moves to RESP when the counter is 0.
- RESP drives `ready`=1 for exactly one cycle, then returns to IDLE unconditionally.
- `req` is ignored in WAIT and RESP. No request queueing.
- Word index is latched `adr[AW+1:2]`. Upper address bits outside the MMIO window are ignored, so the RAM aliases (wraps) every 2^(AW+2) bytes.
- Read: `rdata` is the RAM word at the latched index, presented in the RESP cycle.
- Write: the RAM word is updated at the clock edge ending the RESP cycle. `rdata` shows the old contents during that cycle.
- Misaligned access (latched `adr[1:0]`≠0):
  - `err`=1 and `ready`=1 in RESP, with `rdata`=0.
  - A write is suppressed and memory is unchanged.
- RAM contents are not reset; the initial image is loaded by the testbench or by `$readmemh`.

## Timing
- Reset values: `rdata`=0, `ready`=0, `err`=0, `busy`=0, `led`=0, FSM=IDLE, wait counter=0, cycle counter=0.
- Latency: with accept at edge N, `ready` is high during cycle N+1+`WAIT_CYCLES`.
- Throughput: one access per `WAIT_CYCLES`+2 cycles. A `req` held high continuously is re-accepted in the IDLE cycle after RESP.
- `rdata`/`err` hold their RESP values until the next RESP. Consumers must qualify them with `ready`.
- Reset asserted mid-access (in WAIT or RESP):
  - The FSM returns to IDLE immediately.
  - Any pending write is dropped.
  - No `ready` pulse is produced.
- Changes to `adr`/`wdata`/`we` after accept have no effect on the access in flight.

## Configuration
- Macro: `MCCPU_MEM_MMIO_EN`.
- Defined: latched `adr[31:16]`=16'hFFFF selects the MMIO window instead of the RAM.
  - Offset 0x0000 is the LED register. A write stores `wdata[15:0]` into `led`. A read returns {16'b0, `led`}.
  - Offset 0x0004 is a free-running 32-bit cycle counter that increments every clock since reset and wraps at 2^32. It is read-only; writes are ignored with no `err`.
  - Any other offset in the window reads 0 and ignores writes.
  - MMIO accesses use the same latency as RAM accesses.
  - The misalignment rule applies first.
- Undefined: no window exists. 0xFFFF_xxxx addresses alias into the RAM like any other address, and `led` is constant 0.

## Test plan
- Reset mid-WAIT (`WAIT_CYCLES`=3): assert `rst`=0 one cycle after accept of a write to 0x8 → no `ready` pulse, and a later read of 0x8 returns its prior value.
- Read timing: with `WAIT_CYCLES`=2, preload word 3 = 32'hDEADBEEF, then pulse `req` with `adr`=0xC and `we`=0 → `ready` high only in cycle N+3, with `rdata`=32'hDEADBEEF and `err`=0.
- Write then read: with `WAIT_CYCLES`=0, write 32'h12345678 to 0x40, then read 0x40 → read `rdata`=32'h12345678; during the write's RESP cycle `rdata` shows the old value.
- Misaligned write: write 32'hFFFFFFFF to 0x42 → `ready`=1 with `err`=1 and `rdata`=0, and word 0x40 is unchanged.
- Aliasing with `AW`=10: write 32'hA5A5A5A5 to 0x1000 → a read of 0x0000 returns 32'hA5A5A5A5. Continuous `req` yields one `ready` every `WAIT_CYCLES`+2 cycles.
- MMIO with the macro defined:
  - Write 32'h0000BEEF to 0xFFFF0000 → `led`=16'hBEEF.
  - Two reads of 0xFFFF0004 spaced K cycles apart differ by K.
  - Without the macro, `led` stays 0 and the same write lands in RAM word 0.
